// File: rtl/button_debounce_irq_src.sv
// rtl/button_debounce_irq_src.sv - per-button sync, debounce, edge detect and sticky irq request
// Each channel commits a new level only after DEBOUNCE_CYCLES consecutive mismatching samples.
module button_debounce_irq_src #(
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20,
  parameter int SYNC_STAGES     = 2,
  parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [NUM_BUTTONS-1:0]   btn_in,
  input  logic [NUM_BUTTONS-1:0]   enable,
  input  logic [2*NUM_BUTTONS-1:0] edge_sel,
  input  logic [NUM_BUTTONS-1:0]   irq_ack,
  output logic [NUM_BUTTONS-1:0]   btn_state,
  output logic [NUM_BUTTONS-1:0]   btn_rise,
  output logic [NUM_BUTTONS-1:0]   btn_fall,
  output logic [NUM_BUTTONS-1:0]   irq_req,
  output logic                     irq
);

  localparam logic [0:0] ST_STABLE   = 1'b0;
  localparam logic [0:0] ST_COUNTING = 1'b1;

  localparam logic [CNT_WIDTH-1:0] LP_CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] LP_CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BUTTONS-1:0] r_sync [SYNC_STAGES];
  logic [NUM_BUTTONS-1:0] w_s;
  logic [0:0]             r_fsm  [NUM_BUTTONS];
  logic [CNT_WIDTH-1:0]   r_cnt  [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] r_state;
  logic [NUM_BUTTONS-1:0] r_rise;
  logic [NUM_BUTTONS-1:0] r_fall;
  logic [NUM_BUTTONS-1:0] r_irq_req;
  logic                   r_irq;
  logic [NUM_BUTTONS-1:0] w_set;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= btn_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1] ^ {NUM_BUTTONS{BTN_ACTIVE_LOW}};

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      for (int b = 0; b < NUM_BUTTONS; b++) begin
        r_fsm[b] <= ST_STABLE;
        r_cnt[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BUTTONS; b++) begin
        r_rise[b] <= 1'b0;
        r_fall[b] <= 1'b0;
        case (r_fsm[b])
          ST_STABLE: begin
            if (w_s[b] != r_state[b]) begin
              r_fsm[b] <= ST_COUNTING;
              r_cnt[b] <= LP_CNT_ONE;
            end else begin
              r_cnt[b] <= '0;
            end
          end
          default: begin
            // A single matching sample discards the whole run.
            if (w_s[b] == r_state[b]) begin
              r_fsm[b] <= ST_STABLE;
              r_cnt[b] <= '0;
            end else if (r_cnt[b] == LP_CNT_LAST) begin
              r_state[b] <= w_s[b];
              r_rise[b]  <= w_s[b];
              r_fall[b]  <= ~w_s[b];
              r_fsm[b]   <= ST_STABLE;
              r_cnt[b]   <= '0;
            end else begin
              r_cnt[b] <= r_cnt[b] + LP_CNT_ONE;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    w_set = '0;
    for (int b = 0; b < NUM_BUTTONS; b++) begin
      w_set[b] = enable[b] & ((r_rise[b] & edge_sel[2*b]) | (r_fall[b] & edge_sel[2*b+1]));
    end
  end

  // Set takes priority over a same-cycle acknowledge.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_irq_req <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_irq_req <= w_set | (r_irq_req & ~irq_ack);
      r_irq     <= |r_irq_req;
    end
  end

  assign btn_state = r_state;
  assign btn_rise  = r_rise;
  assign btn_fall  = r_fall;
  assign irq_req   = r_irq_req;
  assign irq       = r_irq;

endmodule
